// File: rtl/fpu_addsub_issue.sv
// fpu_addsub_issue
// Issues add/sub requests into a fixed-latency single-precision subtract pipeline
// (which computes op1 - op2 with no input handshake) and collects the results in
// arrival order into a first-word-fall-through response FIFO.
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake from the core
//   req_op1, req_op2, req_sub      operands; req_sub=0 requests op1 + op2
//   req_tag                        returned alongside the matching response
//   fpu_op1, fpu_op2               registered operands driven into the pipeline
//   fpu_result, fpu_valid          pipeline output; fpu_valid=0 flags underflow
//   rsp_valid/rsp_ready            response handshake (FIFO head)
//   rsp_data, rsp_tag, rsp_uflow   head entry contents (0 when empty)
//   uflow_sticky, uflow_clr        sticky OR of captured underflows and its clear
module fpu_addsub_issue #(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAGW    = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_op1,
    input  logic [31:0]     req_op2,
    input  logic            req_sub,
    input  logic [TAGW-1:0] req_tag,
    output logic [31:0]     fpu_op1,
    output logic [31:0]     fpu_op2,
    input  logic [31:0]     fpu_result,
    input  logic            fpu_valid,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_data,
    output logic [TAGW-1:0] rsp_tag,
    output logic            rsp_uflow,
    output logic            uflow_sticky,
    input  logic            uflow_clr
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic            accept;
    logic            push;
    logic            pop;

    logic [31:0]     op1_q;
    logic [31:0]     op2_q;

    // Valid bit per pipeline position; bit LATENCY marks a result present on fpu_result.
    logic [LATENCY:0] track_q;
    logic [TAGW-1:0]  tag_pipe_q [LATENCY+1];

    logic [31:0]     inflight;
    logic [31:0]     used;

    logic [31:0]     mem_data  [DEPTH];
    logic [TAGW-1:0] mem_tag   [DEPTH];
    logic [DEPTH-1:0] mem_uflow;
    logic [PW-1:0]   wptr_q;
    logic [PW-1:0]   rptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;

    logic            sticky_q;
    logic            sticky_d;

    // ------------------------------------------------------------------
    // Credit: every in-flight op already owns a FIFO slot, so pushes can
    // never overflow. Both terms are registered, so a pop frees credit
    // only on the following cycle.
    // ------------------------------------------------------------------
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i <= LATENCY; i++) begin
            inflight = inflight + 32'(track_q[i]);
        end
        used = 32'(count_q) + inflight;
    end

    assign req_ready = rstn & (used < DEPTH);
    assign accept    = req_valid & req_ready;
    assign push      = track_q[LATENCY];
    assign pop       = rsp_valid & rsp_ready;

    // ------------------------------------------------------------------
    // Operand registers. The pipeline only subtracts, so an add is issued
    // as op1 - (-op2) by flipping the op2 sign.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op1_q <= '0;
            op2_q <= '0;
        end else if (accept) begin
            op1_q <= req_op1;
            op2_q <= {req_op2[31] ^ ~req_sub, req_op2[30:0]};
        end
    end

    assign fpu_op1 = op1_q;
    assign fpu_op2 = op2_q;

    // ------------------------------------------------------------------
    // Latency tracker: one extra stage beyond LATENCY because the operands
    // themselves are registered before entering the pipeline.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            track_q <= '0;
            for (int unsigned i = 0; i <= LATENCY; i++) begin
                tag_pipe_q[i] <= '0;
            end
        end else begin
            track_q <= {track_q[LATENCY-1:0], accept};
            if (accept) begin
                tag_pipe_q[0] <= req_tag;
            end
            for (int unsigned i = 1; i <= LATENCY; i++) begin
                tag_pipe_q[i] <= tag_pipe_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wptr_q]  <= fpu_result;
            mem_tag[wptr_q]   <= tag_pipe_q[LATENCY];
            mem_uflow[wptr_q] <= ~fpu_valid;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    assign rsp_valid = (count_q != '0);
    assign rsp_data  = rsp_valid ? mem_data[rptr_q] : '0;
    assign rsp_tag   = rsp_valid ? mem_tag[rptr_q] : '0;
    assign rsp_uflow = rsp_valid ? mem_uflow[rptr_q] : 1'b0;

    // ------------------------------------------------------------------
    // Sticky underflow: a new underflow in the clearing cycle survives.
    // ------------------------------------------------------------------
    assign sticky_d = (sticky_q & ~uflow_clr) | (push & ~fpu_valid);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign uflow_sticky = sticky_q;

    push_no_overflow: assert property (
        @(posedge clk) disable iff (!rstn) push |-> (count_q != CW'(DEPTH))
    );

endmodule

// File: tb/tb_fpu_addsub_issue.sv
// Bench for fpu_addsub_issue: a directed vector table on a default-sized instance,
// followed by hand-written underflow, stall, streaming and reset sequences. A
// second instance with DEPTH=8 covers sustained one-per-cycle streaming.
module tb_fpu_addsub_issue;

    localparam int unsigned LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic        req_sub;
    logic [3:0]  req_tag;
    logic        rsp_ready;
    logic        uflow_clr;

    logic        req_valid_a, req_ready_a, fpu_valid_a, rsp_valid_a, rsp_uflow_a, sticky_a;
    logic [31:0] fpu_op1_a, fpu_op2_a, fpu_result_a, rsp_data_a;
    logic [3:0]  rsp_tag_a;

    logic        req_valid_b, req_ready_b, fpu_valid_b, rsp_valid_b, rsp_uflow_b, sticky_b;
    logic [31:0] fpu_op1_b, fpu_op2_b, fpu_result_b, rsp_data_b;
    logic [3:0]  rsp_tag_b;

    int n_cmp = 0;
    int n_bad = 0;

    fpu_addsub_issue #(.LATENCY(LAT), .DEPTH(4), .TAGW(4)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_op1(req_op1), .req_op2(req_op2), .req_sub(req_sub), .req_tag(req_tag),
        .fpu_op1(fpu_op1_a), .fpu_op2(fpu_op2_a),
        .fpu_result(fpu_result_a), .fpu_valid(fpu_valid_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_a), .rsp_tag(rsp_tag_a), .rsp_uflow(rsp_uflow_a),
        .uflow_sticky(sticky_a), .uflow_clr(uflow_clr)
    );

    fpu_addsub_issue #(.LATENCY(LAT), .DEPTH(8), .TAGW(4)) dut8 (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_op1(req_op1), .req_op2(req_op2), .req_sub(req_sub), .req_tag(req_tag),
        .fpu_op1(fpu_op1_b), .fpu_op2(fpu_op2_b),
        .fpu_result(fpu_result_b), .fpu_valid(fpu_valid_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_b), .rsp_tag(rsp_tag_b), .rsp_uflow(rsp_uflow_b),
        .uflow_sticky(sticky_b), .uflow_clr(uflow_clr)
    );

    // Stand-in subtract pipeline: two known float pairs give true results,
    // op1 of the form 0x000001xx underflows, everything else returns a + b.
    function automatic logic [32:0] fmodel(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        if (a == 32'h3F80_0000 && b == 32'hC000_0000) return {1'b1, 32'h4040_0000};
        if (a == 32'h4040_0000 && b == 32'h3F80_0000) return {1'b1, 32'h4000_0000};
        if (a[31:8] == 24'h000001) return {1'b0, 32'h0};
        s = a + b;
        return {1'b1, s};
    endfunction

    logic [63:0] pipe_a [LAT];
    logic [63:0] pipe_b [LAT];

    always @(posedge clk) begin
        pipe_a[0] <= {fpu_op1_a, fpu_op2_a};
        pipe_b[0] <= {fpu_op1_b, fpu_op2_b};
        for (int i = 1; i < LAT; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
    end

    assign {fpu_valid_a, fpu_result_a} = fmodel(pipe_a[LAT-1][63:32], pipe_a[LAT-1][31:0]);
    assign {fpu_valid_b, fpu_result_b} = fmodel(pipe_b[LAT-1][63:32], pipe_b[LAT-1][31:0]);

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic        sub;
        logic [3:0]  tag;
        logic [31:0] exp_op2;
        logic [31:0] exp_data;
        logic        exp_uf;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Holds the request until accepted; returns just after the accept edge.
    task automatic issue_a(input logic [31:0] o1, input logic [31:0] o2, input logic s,
                           input logic [3:0] t);
        int n;
        n = 0;
        req_op1 = o1;
        req_op2 = o2;
        req_sub = s;
        req_tag = t;
        req_valid_a = 1'b1;
        while (!req_ready_a && n < 50) begin
            step();
            n++;
        end
        check("issue_ready", 32'(req_ready_a), 32'd1);
        step();
        req_valid_a = 1'b0;
    endtask

    task automatic pop_check_a(input string name, input logic [31:0] d, input logic [3:0] t,
                               input logic uf);
        int n;
        n = 0;
        while (!rsp_valid_a && n < 50) begin
            step();
            n++;
        end
        check({name, "_valid"}, 32'(rsp_valid_a), 32'd1);
        check({name, "_data"}, rsp_data_a, d);
        check({name, "_tag"}, 32'(rsp_tag_a), 32'(t));
        check({name, "_uflow"}, 32'(rsp_uflow_a), 32'(uf));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        logic        uf_acc;
        int          acc_cnt;
        int          t;
        int          rcv;
        int          sent;
        int          drops;
        int          seen;
        logic        acc;
        logic [35:0] q [$];
        logic [35:0] e;
        logic [31:0] o1, o2;

        vecs[0] = '{32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd5, 32'hC000_0000, 32'h4040_0000, 1'b0};
        vecs[1] = '{32'h4040_0000, 32'h3F80_0000, 1'b1, 4'd6, 32'h3F80_0000, 32'h4000_0000, 1'b0};
        vecs[2] = '{32'h1234_5678, 32'h0000_0010, 1'b0, 4'd1, 32'h8000_0010, 32'h9234_5688, 1'b0};
        vecs[3] = '{32'h0000_0105, 32'h8000_0001, 1'b1, 4'd2, 32'h8000_0001, 32'h0000_0000, 1'b1};
        vecs[4] = '{32'h7F00_0000, 32'h00FF_FFFF, 1'b1, 4'hF, 32'h00FF_FFFF, 32'h7FFF_FFFF, 1'b0};
        vecs[5] = '{32'hC000_0000, 32'hC000_0000, 1'b0, 4'd0, 32'h4000_0000, 32'h0000_0000, 1'b0};

        rstn = 1'b1;
        req_op1 = '0;
        req_op2 = '0;
        req_sub = 1'b0;
        req_tag = '0;
        rsp_ready = 1'b0;
        uflow_clr = 1'b0;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        #2 rstn = 1'b0;
        step();
        step();

        // Reset state
        req_valid_a = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready_a), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
        check("rst_fpu_op1", fpu_op1_a, 32'd0);
        check("rst_fpu_op2", fpu_op2_a, 32'd0);
        check("rst_sticky", 32'(sticky_a), 32'd0);
        check("rst_rsp_data", rsp_data_a, 32'd0);
        check("rst_rsp_tag", 32'(rsp_tag_a), 32'd0);
        req_valid_a = 1'b0;
        rstn = 1'b1;
        step();

        // Vector table: exact accept-to-response timing, one op at a time
        uf_acc = 1'b0;
        for (int i = 0; i < 6; i++) begin
            issue_a(vecs[i].op1, vecs[i].op2, vecs[i].sub, vecs[i].tag);
            check($sformatf("v%0d_fpu_op1", i), fpu_op1_a, vecs[i].op1);
            check($sformatf("v%0d_fpu_op2", i), fpu_op2_a, vecs[i].exp_op2);
            repeat (LAT) step();
            check($sformatf("v%0d_early", i), 32'(rsp_valid_a), 32'd0);
            step();
            check($sformatf("v%0d_valid", i), 32'(rsp_valid_a), 32'd1);
            check($sformatf("v%0d_data", i), rsp_data_a, vecs[i].exp_data);
            check($sformatf("v%0d_tag", i), 32'(rsp_tag_a), 32'(vecs[i].tag));
            check($sformatf("v%0d_uflow", i), 32'(rsp_uflow_a), 32'(vecs[i].exp_uf));
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            check($sformatf("v%0d_popped", i), 32'(rsp_valid_a), 32'd0);
            uf_acc = uf_acc | vecs[i].exp_uf;
            check($sformatf("v%0d_sticky", i), 32'(sticky_a), 32'(uf_acc));
        end
        uflow_clr = 1'b1;
        step();
        uflow_clr = 1'b0;
        check("tbl_sticky_clr", 32'(sticky_a), 32'd0);

        // Underflow on the middle of three back-to-back ops
        issue_a(32'h0000_0011, 32'h0, 1'b1, 4'd1);
        issue_a(32'h0000_0122, 32'h0, 1'b1, 4'd2);
        issue_a(32'h0000_0033, 32'h0, 1'b1, 4'd3);
        pop_check_a("uf0", 32'h0000_0011, 4'd1, 1'b0);
        pop_check_a("uf1", 32'h0000_0000, 4'd2, 1'b1);
        pop_check_a("uf2", 32'h0000_0033, 4'd3, 1'b0);
        check("uf_sticky_set", 32'(sticky_a), 32'd1);
        uflow_clr = 1'b1;
        step();
        uflow_clr = 1'b0;
        check("uf_sticky_clr", 32'(sticky_a), 32'd0);
        // Clear coinciding with an underflow push: the set wins
        issue_a(32'h0000_0144, 32'h0, 1'b1, 4'd9);
        repeat (LAT) step();
        uflow_clr = 1'b1;
        step();
        uflow_clr = 1'b0;
        check("uf_clr_vs_set", 32'(sticky_a), 32'd1);
        pop_check_a("uf3", 32'h0000_0000, 4'd9, 1'b1);
        uflow_clr = 1'b1;
        step();
        uflow_clr = 1'b0;

        // Stall: consumer blocked, 8 requests offered back to back
        t = 0;
        acc_cnt = 0;
        req_sub = 1'b1;
        req_op2 = '0;
        for (int c = 0; c < 12; c++) begin
            req_op1 = 32'h1000 + 32'(t);
            req_tag = 4'(t);
            req_valid_a = 1'b1;
            acc = req_ready_a;
            step();
            if (acc) begin
                t++;
                acc_cnt++;
            end
        end
        check("stall_accepts", 32'(acc_cnt), 32'd4);
        check("stall_ready_low", 32'(req_ready_a), 32'd0);
        rsp_ready = 1'b1;
        rcv = 0;
        for (int c = 0; c < 100 && rcv < 8; c++) begin
            req_op1 = 32'h1000 + 32'(t);
            req_tag = 4'(t);
            req_valid_a = (t < 8);
            acc = req_valid_a && req_ready_a;
            if (rsp_valid_a) begin
                check($sformatf("stall_tag%0d", rcv), 32'(rsp_tag_a), 32'(rcv));
                check($sformatf("stall_data%0d", rcv), rsp_data_a, 32'h1000 + 32'(rcv));
                rcv++;
            end
            step();
            if (acc) t++;
        end
        req_valid_a = 1'b0;
        rsp_ready = 1'b0;
        check("stall_total_accepts", 32'(t), 32'd8);
        check("stall_total_rsps", 32'(rcv), 32'd8);

        // Streaming on the DEPTH=8 instance: one accept per cycle, in-order results
        rsp_ready = 1'b1;
        sent = 0;
        rcv = 0;
        drops = 0;
        for (int c = 0; c < 200 && rcv < 20; c++) begin
            if (sent < 20) begin
                o1 = 32'h2000_0000 + 32'(sent * 3);
                o2 = 32'(sent);
                req_op1 = o1;
                req_op2 = o2;
                req_sub = sent[0];
                req_tag = 4'(sent);
                req_valid_b = 1'b1;
            end else begin
                req_valid_b = 1'b0;
            end
            if (req_valid_b && !req_ready_b) drops++;
            if (rsp_valid_b) begin
                if (q.size() == 0) begin
                    check("stream_unexpected_rsp", 32'(rsp_valid_b), 32'd0);
                end else begin
                    e = q.pop_front();
                    check($sformatf("stream_tag%0d", rcv), 32'(rsp_tag_b), 32'(e[35:32]));
                    check($sformatf("stream_data%0d", rcv), rsp_data_b, e[31:0]);
                    check($sformatf("stream_uflow%0d", rcv), 32'(rsp_uflow_b), 32'd0);
                end
                rcv++;
            end
            acc = req_valid_b && req_ready_b;
            e = {req_tag, req_op1 + (req_sub ? req_op2 : (req_op2 ^ 32'h8000_0000))};
            step();
            if (acc) begin
                q.push_back(e);
                sent++;
            end
        end
        req_valid_b = 1'b0;
        rsp_ready = 1'b0;
        check("stream_sent", 32'(sent), 32'd20);
        check("stream_rcvd", 32'(rcv), 32'd20);
        check("stream_ready_drops", 32'(drops), 32'd0);

        // Reset with two ops in flight and one waiting in the FIFO
        issue_a(32'h0000_3000, 32'h0, 1'b1, 4'd1);
        step();
        step();
        issue_a(32'h0000_3001, 32'h0, 1'b1, 4'd2);
        issue_a(32'h0000_3002, 32'h0, 1'b1, 4'd3);
        check("mid_pre_valid", 32'(rsp_valid_a), 32'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rsp_valid_a), 32'd0);
        check("mid_rst_ready", 32'(req_ready_a), 32'd0);
        check("mid_rst_data", rsp_data_a, 32'd0);
        check("mid_rst_op1", fpu_op1_a, 32'd0);
        step();
        step();
        rstn = 1'b1;
        rsp_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (rsp_valid_a) seen++;
            step();
        end
        rsp_ready = 1'b0;
        check("mid_no_stale", 32'(seen), 32'd0);
        issue_a(vecs[0].op1, vecs[0].op2, vecs[0].sub, vecs[0].tag);
        repeat (LAT + 1) step();
        check("mid_new_valid", 32'(rsp_valid_a), 32'd1);
        check("mid_new_data", rsp_data_a, 32'h4040_0000);
        check("mid_new_tag", 32'(rsp_tag_a), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
